// File: rtl/mem_pkg.sv
// Shared types and constants for the mem_responder backing-store model.
package mem_pkg;

    typedef enum logic [1:0] {IDLE, BUSY, RESP} mem_state_t;

    localparam logic [63:0] INIT_PATTERN     = 64'hA5A5_A5A5_A5A5_A5A5;
    localparam int          WORD_OFFSET_BITS = 3;

endpackage

// File: rtl/mem_responder_array.sv
// Single-port word array with a per-word "written" flag; synchronous write,
// combinational read. Only the flags are cleared by reset, never the data.
module mem_array #(
    parameter int W          = 64,
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  clk_in,
    input  logic                  rst_N_in,
    input  logic                  we_i,
    input  logic [DEPTH_LOG2-1:0] idx_i,
    input  logic [W-1:0]          wdata_i,
    output logic [W-1:0]          rdata_o,
    output logic                  written_o
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [W-1:0]     mem_q [DEPTH];
    logic [DEPTH-1:0] written_q;

    always_ff @(posedge clk_in) begin
        if (we_i) begin
            mem_q[idx_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_N_in) begin
            written_q <= '0;
        end else if (we_i) begin
            written_q[idx_i] <= 1'b1;
        end
    end

    assign rdata_o   = mem_q[idx_i];
    assign written_o = written_q[idx_i];

endmodule

// File: rtl/mem_responder.sv
// Lower-level memory model answering one cache request at a time after LATENCY cycles.
// Define MEM_INIT_PATTERN_EN to make never-written words read as an address-derived fill pattern.
module mem_responder
    import mem_pkg::*;
#(
    parameter int W          = 64,
    parameter int DEPTH_LOG2 = 10,
    parameter int LATENCY    = 4
) (
    input  logic         clk_in,
    input  logic         rst_N_in,
    input  logic         cs_in,
    input  logic         hc_valid_in,
    output logic         hc_ready_out,
    input  logic [W-1:0] hc_addr_in,
    input  logic [W-1:0] hc_value_in,
    input  logic         hc_we_in,
    output logic         hc_valid_out,
    input  logic         hc_ready_in,
    output logic [W-1:0] hc_addr_out,
    output logic [W-1:0] hc_value_out,
    output logic         hc_we_out
);

    mem_state_t state_q, state_d;
    logic [7:0]   cnt_q, cnt_d;
    logic         valid_q, valid_d;
    logic [W-1:0] addr_q, addr_d;
    logic [W-1:0] value_q, value_d;
    logic         we_q, we_d;

    logic                  accept;
    logic [DEPTH_LOG2-1:0] idx;
    logic [W-1:0]          rdata;
    logic                  written;
    logic [W-1:0]          fill;
    logic [W-1:0]          rd_value;

    assign hc_ready_out = (state_q == IDLE) && cs_in;
    assign accept       = hc_valid_in && hc_ready_out;
    assign idx          = hc_addr_in[DEPTH_LOG2+WORD_OFFSET_BITS-1:WORD_OFFSET_BITS];

`ifdef MEM_INIT_PATTERN_EN
    assign fill = {hc_addr_in[W-1:WORD_OFFSET_BITS], {WORD_OFFSET_BITS{1'b0}}} ^ W'(INIT_PATTERN);
`else
    assign fill = '0;
`endif

    assign rd_value = written ? rdata : fill;

    // Array write is suppressed during reset so a request racing reset leaves no trace.
    mem_array #(
        .W          (W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_array (
        .clk_in    (clk_in),
        .rst_N_in  (rst_N_in),
        .we_i      (accept && hc_we_in && rst_N_in),
        .idx_i     (idx),
        .wdata_i   (hc_value_in),
        .rdata_o   (rdata),
        .written_o (written)
    );

    always_ff @(posedge clk_in) begin
        if (!rst_N_in) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            addr_q  <= '0;
            value_q <= '0;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            addr_q  <= addr_d;
            value_q <= value_d;
            we_q    <= we_d;
        end
    end

    // Counter is loaded with LATENCY-1 so valid rises exactly LATENCY edges after accept.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        addr_d  = addr_q;
        value_d = value_q;
        we_d    = we_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    addr_d  = hc_addr_in;
                    we_d    = hc_we_in;
                    value_d = hc_we_in ? hc_value_in : rd_value;
                    cnt_d   = 8'(LATENCY - 1);
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q == 8'd0) begin
                    valid_d = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            RESP: begin
                if (hc_ready_in) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign hc_valid_out = valid_q;
    assign hc_addr_out  = addr_q;
    assign hc_value_out = value_q;
    assign hc_we_out    = we_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed self-checking bench for mem_responder (LATENCY=4, DEPTH_LOG2=10).
// Honours MEM_INIT_PATTERN_EN when computing expected reads of unwritten words.
module tb_mem_responder;

    localparam int          W   = 64;
    localparam int          DL  = 10;
    localparam int          LAT = 4;
    localparam logic [63:0] PAT = 64'hA5A5_A5A5_A5A5_A5A5;

    logic         clk = 1'b0;
    logic         rstN;
    logic         csIn;
    logic         validIn;
    logic         readyOut;
    logic [W-1:0] addrIn;
    logic [W-1:0] valueIn;
    logic         weIn;
    logic         validOut;
    logic         readyIn;
    logic [W-1:0] addrOut;
    logic [W-1:0] valueOut;
    logic         weOut;

    int checkCount = 0;
    int errorCount = 0;

    always #5 clk = ~clk;

    mem_responder #(.W(W), .DEPTH_LOG2(DL), .LATENCY(LAT)) dut (
        .clk_in       (clk),
        .rst_N_in     (rstN),
        .cs_in        (csIn),
        .hc_valid_in  (validIn),
        .hc_ready_out (readyOut),
        .hc_addr_in   (addrIn),
        .hc_value_in  (valueIn),
        .hc_we_in     (weIn),
        .hc_valid_out (validOut),
        .hc_ready_in  (readyIn),
        .hc_addr_out  (addrOut),
        .hc_value_out (valueOut),
        .hc_we_out    (weOut)
    );

    function automatic logic [63:0] unwrittenValue(input logic [63:0] a);
`ifdef MEM_INIT_PATTERN_EN
        return {a[63:3], 3'b000} ^ PAT;
`else
        return 64'd0 & a;
`endif
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Presents a request for exactly one edge; callers check readiness first.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] v, input logic we);
        validIn = 1'b1;
        addrIn  = a;
        valueIn = v;
        weIn    = we;
        tick();
        validIn = 1'b0;
    endtask

    // Counts edges after the accept edge until valid appears; 99 on timeout.
    task automatic measureLatency(output int n);
        n = 99;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (validOut === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic test_reset;
        checkCount++;
        if (validOut !== 1'b0) begin
            errorCount++;
            $display("[TB] FAIL reset_valid: got %b, expected 0", validOut);
        end
        rstN = 1'b1;
        tick();
        checkCount++;
        if ({validOut, weOut, addrOut, valueOut} !== {1'b0, 1'b0, 64'd0, 64'd0}) begin
            errorCount++;
            $display("[TB] FAIL reset_outputs: got v=%b we=%b a=%h d=%h, expected all zero",
                     validOut, weOut, addrOut, valueOut);
        end
        checkCount++;
        if (readyOut !== 1'b1) begin
            errorCount++;
            $display("[TB] FAIL reset_ready: got %b, expected 1", readyOut);
        end
    endtask

    task automatic test_read_unwritten;
        int n;
        checkCount++;
        if (readyOut !== 1'b1) begin
            errorCount++;
            $display("[TB] FAIL read0_ready: got %b, expected 1", readyOut);
        end
        issue(64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        measureLatency(n);
        checkCount++;
        if (n !== LAT) begin
            errorCount++;
            $display("[TB] FAIL read0_latency: got %0d, expected %0d", n, LAT);
        end
        checkCount++;
        if ({weOut, addrOut, valueOut} !== {1'b0, 64'h0, unwrittenValue(64'h0)}) begin
            errorCount++;
            $display("[TB] FAIL read0_resp: got we=%b a=%h d=%h, expected we=0 a=0 d=%h",
                     weOut, addrOut, valueOut, unwrittenValue(64'h0));
        end
        tick();
        checkCount++;
        if ({validOut, readyOut} !== 2'b01) begin
            errorCount++;
            $display("[TB] FAIL read0_done: got valid=%b ready=%b, expected 0 1", validOut, readyOut);
        end
    endtask

    task automatic test_write_read;
        int n;
        issue(64'h40, 64'h0123_4567_89AB_CDEF, 1'b1);
        measureLatency(n);
        checkCount++;
        if (n !== LAT) begin
            errorCount++;
            $display("[TB] FAIL write_latency: got %0d, expected %0d", n, LAT);
        end
        checkCount++;
        if ({weOut, addrOut, valueOut} !== {1'b1, 64'h40, 64'h0123_4567_89AB_CDEF}) begin
            errorCount++;
            $display("[TB] FAIL write_ack: got we=%b a=%h d=%h, expected we=1 a=40 d=0123456789abcdef",
                     weOut, addrOut, valueOut);
        end
        tick();
        issue(64'h40, 64'h0, 1'b0);
        measureLatency(n);
        checkCount++;
        if ({n, weOut, valueOut} !== {LAT, 1'b0, 64'h0123_4567_89AB_CDEF}) begin
            errorCount++;
            $display("[TB] FAIL write_readback: got lat=%0d we=%b d=%h, expected lat=4 we=0 d=0123456789abcdef",
                     n, weOut, valueOut);
        end
        tick();
    endtask

    task automatic test_backpressure;
        int n;
        readyIn = 1'b0;
        issue(64'h40, 64'h0, 1'b0);
        measureLatency(n);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkCount++;
            if ({validOut, readyOut, weOut, addrOut, valueOut} !==
                {1'b1, 1'b0, 1'b0, 64'h40, 64'h0123_4567_89AB_CDEF}) begin
                errorCount++;
                $display("[TB] FAIL bp_hold%0d: got v=%b rdy=%b we=%b a=%h d=%h, expected v=1 rdy=0 we=0 a=40 d=0123456789abcdef",
                         i, validOut, readyOut, weOut, addrOut, valueOut);
            end
        end
        readyIn = 1'b1;
        #1;
        checkCount++;
        if (readyOut !== 1'b0) begin
            errorCount++;
            $display("[TB] FAIL bp_ready_early: got %b, expected 0", readyOut);
        end
        tick();
        checkCount++;
        if ({validOut, readyOut} !== 2'b01) begin
            errorCount++;
            $display("[TB] FAIL bp_release: got valid=%b ready=%b, expected 0 1", validOut, readyOut);
        end
    endtask

    task automatic test_aliasing;
        int n;
        issue(64'h2000, 64'hDEAD_BEEF_DEAD_BEEF, 1'b1);
        measureLatency(n);
        tick();
        issue(64'h0, 64'h0, 1'b0);
        measureLatency(n);
        checkCount++;
        if ({n, addrOut, valueOut} !== {LAT, 64'h0, 64'hDEAD_BEEF_DEAD_BEEF}) begin
            errorCount++;
            $display("[TB] FAIL alias_read: got lat=%0d a=%h d=%h, expected lat=4 a=0 d=deadbeefdeadbeef",
                     n, addrOut, valueOut);
        end
        tick();
    endtask

    task automatic test_reset_mid_busy;
        int n;
        issue(64'h40, 64'h0, 1'b0);
        tick();
        rstN = 1'b0;
        tick();
        rstN = 1'b1;
        for (int i = 0; i < 5; i++) begin
            checkCount++;
            if ({validOut, readyOut} !== 2'b01) begin
                errorCount++;
                $display("[TB] FAIL rst_busy%0d: got valid=%b ready=%b, expected 0 1", i, validOut, readyOut);
            end
            tick();
        end
        issue(64'h40, 64'h0, 1'b0);
        measureLatency(n);
        checkCount++;
        if ({n, valueOut} !== {LAT, unwrittenValue(64'h40)}) begin
            errorCount++;
            $display("[TB] FAIL rst_reread: got lat=%0d d=%h, expected lat=4 d=%h",
                     n, valueOut, unwrittenValue(64'h40));
        end
        tick();
    endtask

    task automatic test_chip_select;
        int n;
        csIn    = 1'b0;
        validIn = 1'b1;
        addrIn  = 64'h8;
        weIn    = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            checkCount++;
            if ({readyOut, validOut} !== 2'b00) begin
                errorCount++;
                $display("[TB] FAIL cs_low%0d: got ready=%b valid=%b, expected 0 0", i, readyOut, validOut);
            end
        end
        csIn = 1'b1;
        #1;
        checkCount++;
        if (readyOut !== 1'b1) begin
            errorCount++;
            $display("[TB] FAIL cs_high_ready: got %b, expected 1", readyOut);
        end
        tick();
        validIn = 1'b0;
        measureLatency(n);
        checkCount++;
        if ({n, addrOut, valueOut} !== {LAT, 64'h8, unwrittenValue(64'h8)}) begin
            errorCount++;
            $display("[TB] FAIL cs_resp: got lat=%0d a=%h d=%h, expected lat=4 a=8 d=%h",
                     n, addrOut, valueOut, unwrittenValue(64'h8));
        end
        tick();
    endtask

    initial begin
        rstN    = 1'b0;
        csIn    = 1'b1;
        validIn = 1'b0;
        addrIn  = '0;
        valueIn = '0;
        weIn    = 1'b0;
        readyIn = 1'b1;
        repeat (3) tick();
        test_reset();
        test_read_unwritten();
        test_write_read();
        test_backpressure();
        test_aliasing();
        test_reset_mid_busy();
        test_chip_select();
        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Lower-level backing-store model that answers the cache's lower-level (lc_*) request/response interface.
- Accepts one request at a time from the cache and performs the read or write against an internal word array.
- Returns a response after a programmable latency and holds it until the cache accepts it.
- Sits below `cache`: cache lc_*_out drive this block's hc_*_in, and this block's hc_*_out drive cache lc_*_in. Used for cache unit benches and as the memory end of subsystem benches.

Parameters:
- W, 64: address and data width in bits.
- DEPTH_LOG2, 10: log2 of the number of W-bit words stored.
- LATENCY, 4: cycles from the request-accept edge to hc_valid_out rising; legal range 1..255.

Ports:
- clk_in  input  1  clock.
- rst_N_in  input  1  synchronous, active-low reset.
- cs_in  input  1  chip select; when low, no new request is accepted.
- hc_valid_in  input  1  request valid from cache (cache lc_valid_out).
- hc_ready_out  output  1  block can accept a request (to cache lc_ready_in).
- hc_addr_in  input  W  request byte address.
- hc_value_in  input  W  write data.
- hc_we_in  input  1  1 = write, 0 = read (cache we_out).
- hc_valid_out  output  1  response valid (to cache lc_valid_in).
- hc_ready_in  input  1  cache ready for the response (cache lc_ready_out).
- hc_addr_out  output  W  address of the request being answered.
- hc_value_out  output  W  read data, or the written data on a write ack.
- hc_we_out  output  1  1 = this response is a write ack.

Behaviour:
- One clock domain. rst_N_in is sampled only at posedge clk_in (synchronous, active-low).
- Reset values:
  - hc_valid_out=0, hc_addr_out=0, hc_value_out=0, hc_we_out=0.
  - State=IDLE, latency counter=0.
  - All per-word "written" bits cleared.
  - hc_ready_out=1 in the first cycle after reset is released, provided cs_in=1.
- hc_ready_out = (state==IDLE) && cs_in. It is combinational and has no dependence on hc_valid_in.
- Accept = hc_valid_in && hc_ready_out at posedge. On the accept edge:
  - Latch addr and we into the response registers.
  - Write: store hc_value_in at index, set the written bit, latch value = hc_value_in.
  - Read: latch value = array[index], or 0 if the word's written bit is clear.
  - Load the counter with LATENCY-1 and go to BUSY.
- Index = hc_addr_in[DEPTH_LOG2+2:3] (8-byte words). Bits [2:0] are ignored. Bits above DEPTH_LOG2+2 are ignored, so addresses alias modulo 2^(DEPTH_LOG2+3) bytes.
- BUSY: the counter decrements each cycle. At the edge where the counter reads 0, set hc_valid_out=1 and go to RESP. hc_valid_out therefore rises exactly LATENCY cycles after the accept edge.
- RESP:
  - hc_valid_out, hc_addr_out, hc_value_out and hc_we_out are held stable while hc_ready_in=0 (no timeout).
  - At the edge with hc_ready_in=1: clear hc_valid_out and go to IDLE. hc_ready_out rises the following cycle.
  - Minimum request-to-request spacing is LATENCY+2 cycles.
- At most one request is outstanding, so there are no read/write hazards. A read issued after a write ack returns the new data.
- cs_in low during BUSY or RESP does not abort the transaction; the response still completes.
- hc_valid_in asserted while not ready is ignored. The requester must keep it held; requests are not queued.
- Reset mid-transaction: on the next edge with rst_N_in=0, any pending response is dropped, hc_valid_out=0, state=IDLE, and all written bits are cleared. Array data bits are not reset.
- States: IDLE -> BUSY (on accept) -> RESP (counter==0) -> IDLE (hc_ready_in).

Optional Feature:
- Macro: MEM_INIT_PATTERN_EN.
- Defined: a read of a never-written word returns {addr[W-1:3], 3'b000} XOR 64'hA5A5_A5A5_A5A5_A5A5 (a fill pattern derived from the word address) instead of 0. This lets benches detect reads of unwritten data.
- Undefined: a never-written word reads as 0.
- Written words behave identically with or without the macro.

Decomposition:
- Package mem_pkg holds:
  - typedef enum logic [1:0] {IDLE, BUSY, RESP} mem_state_t;
  - localparam INIT_PATTERN = 64'hA5A5_A5A5_A5A5_A5A5;
  - localparam WORD_OFFSET_BITS = 3.
- One sub-module, mem_array: a single-port array (DEPTH words of W bits) plus the written-bit vector.
  - Synchronous write; combinational read.
  - Written bits use synchronous clear on reset.
- The FSM, latency counter and response registers live in the top-level mem_responder.

Test Plan (all with LATENCY=4, DEPTH_LOG2=10):
- Reset, macro off: read 0x0 accepted at edge k -> hc_valid_out=1 at edge k+4, hc_value_out=0, hc_we_out=0, hc_addr_out=0x0.
- Write 0x40 with 0x0123456789ABCDEF -> ack at k+4 with hc_we_out=1 and hc_value_out=0x0123456789ABCDEF. A subsequent read of 0x40 returns 0x0123456789ABCDEF.
- Backpressure: read 0x40 with hc_ready_in=0 for 3 cycles after valid -> outputs held stable; hc_ready_out stays 0 until the cycle after the hc_ready_in=1 edge.
- Aliasing: write 0x2000 with 0xDEADBEEFDEADBEEF, then read 0x0 -> 0xDEADBEEFDEADBEEF.
- Reset mid-BUSY (2 cycles after accepting a read of 0x40) -> hc_valid_out stays 0 and hc_ready_out=1 after reset. A re-read of 0x40 returns 0, or 0x40^INIT_PATTERN with MEM_INIT_PATTERN_EN defined.
- cs_in=0 with hc_valid_in=1 for 5 cycles -> hc_ready_out=0 and no response. Raising cs_in -> accepted the same cycle.
